// File: rtl/stream_arbiter_qos_pkt.sv
// Packet-aware N-to-1 stream arbiter with QoS priority and rotating
// round-robin among equal-priority streams. A grant covers a whole packet
// (through the beat carrying last), and the output is a registered slice
// with full valid/ready backpressure.
//
// Ports:
//   clk, rst_n      clock (rising edge), async active-low reset
//   s_data_in       per-stream data
//   s_qos_in        per-stream QoS (larger = higher, 0 = wildcard)
//   s_last_in       per-stream end-of-packet
//   s_valid_in      per-stream valid
//   s_ready_out     per-stream ready, one-hot or zero
//   m_data_out      registered data
//   m_qos_out       QoS latched at grant time
//   m_id_out        index of the granted stream
//   m_last_out      registered last
//   m_valid_out     registered valid
//   m_ready_in      downstream ready
//
// state | meaning
// IDLE  | arbitrate among candidates, no transfer this cycle
// BUSY  | forward beats of the granted stream until its last beat
module stream_arbiter_qos_pkt #(
  parameter int T_DATA_WIDTH = 8,
  parameter int T_QOS__WIDTH = 4,
  parameter int STREAM_COUNT = 4,
  parameter int T_ID___WIDTH = $clog2(STREAM_COUNT)
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [STREAM_COUNT-1:0][T_DATA_WIDTH-1:0] s_data_in,
  input  logic [STREAM_COUNT-1:0][T_QOS__WIDTH-1:0] s_qos_in,
  input  logic [STREAM_COUNT-1:0]                  s_last_in,
  input  logic [STREAM_COUNT-1:0]                  s_valid_in,
  output logic [STREAM_COUNT-1:0]                  s_ready_out,
  output logic [T_DATA_WIDTH-1:0]                  m_data_out,
  output logic [T_QOS__WIDTH-1:0]                  m_qos_out,
  output logic [T_ID___WIDTH-1:0]                  m_id_out,
  output logic                                     m_last_out,
  output logic                                     m_valid_out,
  input  logic                                     m_ready_in
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [T_ID___WIDTH-1:0] LAST_ID = T_ID___WIDTH'(STREAM_COUNT - 1);

  state_t                  state, state_nxt;
  logic [T_ID___WIDTH-1:0] grant, rr_ptr, winner;
  logic [T_QOS__WIDTH-1:0] qos_lat, max_q;
  logic [STREAM_COUNT-1:0] cand;
  logic                    any_cand, found, out_free, accept, grant_last;

  // Highest nonzero QoS among valid streams; stays 0 when none is nonzero,
  // which makes every valid (qos==0) stream a candidate in that case.
  always_comb begin
    max_q = '0;
    for (int i = 0; i < STREAM_COUNT; i++) begin
      if (s_valid_in[i] && (s_qos_in[i] > max_q)) max_q = s_qos_in[i];
    end
  end

  always_comb begin
    cand = '0;
    for (int i = 0; i < STREAM_COUNT; i++) begin
      cand[i] = s_valid_in[i] && ((s_qos_in[i] == '0) || (s_qos_in[i] == max_q));
    end
  end

  assign any_cand = |cand;

  // First candidate at or after rr_ptr, wrapping modulo STREAM_COUNT.
  always_comb begin : pick_winner
    int idx;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < STREAM_COUNT; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= STREAM_COUNT) idx = idx - STREAM_COUNT;
      if (!found && cand[idx]) begin
        winner = T_ID___WIDTH'(idx);
        found  = 1'b1;
      end
    end
  end

  assign out_free   = !m_valid_out || m_ready_in;
  assign accept     = (state == BUSY) && s_valid_in[grant] && out_free;
  assign grant_last = s_last_in[grant];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_cand) state_nxt = BUSY;
      BUSY:    if (accept && grant_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_ready_out = '0;
    if (state == BUSY) s_ready_out[grant] = out_free;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant       <= '0;
      rr_ptr      <= '0;
      qos_lat     <= '0;
      m_data_out  <= '0;
      m_qos_out   <= '0;
      m_id_out    <= '0;
      m_last_out  <= 1'b0;
      m_valid_out <= 1'b0;
    end else begin
      if ((state == IDLE) && any_cand) begin
        grant   <= winner;
        qos_lat <= s_qos_in[winner];
      end
      if (accept && grant_last) begin
        rr_ptr <= (grant == LAST_ID) ? '0 : grant + T_ID___WIDTH'(1);
      end
      // Load wins over drain so a packet streams at one beat per clock.
      if (accept) begin
        m_valid_out <= 1'b1;
        m_data_out  <= s_data_in[grant];
        m_last_out  <= grant_last;
        m_id_out    <= grant;
        m_qos_out   <= qos_lat;
      end else if (m_ready_in) begin
        m_valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_arbiter_qos_pkt.sv
module tb_stream_arbiter_qos_pkt;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int QW = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_n;
  logic [N-1:0][DW-1:0]   s_data;
  logic [N-1:0][QW-1:0]   s_qos;
  logic [N-1:0]           s_last, s_valid, s_ready;
  logic [DW-1:0]          m_data;
  logic [QW-1:0]          m_qos;
  logic [IW-1:0]          m_id;
  logic                   m_last, m_valid, m_ready;

  int total = 0;
  int bad   = 0;

  stream_arbiter_qos_pkt #(
    .T_DATA_WIDTH(DW), .T_QOS__WIDTH(QW), .STREAM_COUNT(N), .T_ID___WIDTH(IW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_data_in(s_data), .s_qos_in(s_qos), .s_last_in(s_last), .s_valid_in(s_valid),
    .s_ready_out(s_ready),
    .m_data_out(m_data), .m_qos_out(m_qos), .m_id_out(m_id), .m_last_out(m_last),
    .m_valid_out(m_valid), .m_ready_in(m_ready)
  );

  // Per-stream packet sources for the directed scenarios.
  int          plen [N];
  int          beat [N];
  int          drop_at [N];
  int          drop_left [N];
  bit          en [N];
  bit          rep [N];
  logic [7:0]  base [N];

  // Beats seen leaving the output port, and per-cycle snapshots.
  logic [7:0]  rx_data [$];
  int          rx_id [$];
  int          rx_qos [$];
  int          rx_cyc [$];
  int          cyc_no;
  logic [N-1:0] snap_rdy [64];
  logic        snap_mv [64];
  logic [7:0]  snap_md [64];

  task automatic clear_stim();
    for (int i = 0; i < N; i++) begin
      en[i] = 0; rep[i] = 0; plen[i] = 1; beat[i] = 0;
      drop_at[i] = -1; drop_left[i] = 0; base[i] = '0;
    end
    s_qos = '0; s_data = '0; s_last = '0; s_valid = '0;
    rx_data.delete(); rx_id.delete(); rx_qos.delete(); rx_cyc.delete();
    cyc_no = 0; m_ready = 1'b1;
  endtask

  // Leaves time at posedge+1 with reset released and the DUT in IDLE.
  task automatic do_reset();
    rst_n = 1'b0; s_valid = '0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // One clock of the packet sources: drive, sample at posedge-4, advance.
  task automatic cyc();
    bit dn [N];
    logic [N-1:0] rdy, vld;
    for (int i = 0; i < N; i++) begin
      dn[i] = en[i] && (beat[i] < plen[i]) && (drop_at[i] == beat[i]) && (drop_left[i] > 0);
      s_valid[i] = en[i] && (beat[i] < plen[i]) && !dn[i];
      s_data[i]  = base[i] + 8'(beat[i]);
      s_last[i]  = (beat[i] == plen[i] - 1);
    end
    #1;
    rdy = s_ready; vld = s_valid;
    if (cyc_no < 64) begin
      snap_rdy[cyc_no] = s_ready; snap_mv[cyc_no] = m_valid; snap_md[cyc_no] = m_data;
    end
    if (m_valid && m_ready) begin
      rx_data.push_back(m_data); rx_id.push_back(int'(m_id));
      rx_qos.push_back(int'(m_qos)); rx_cyc.push_back(cyc_no);
    end
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      if (dn[i]) drop_left[i]--;
      if (rdy[i] && vld[i]) begin
        beat[i]++;
        if (rep[i] && beat[i] == plen[i]) beat[i] = 0;
      end
    end
    cyc_no++;
  endtask

  task automatic test_reset();
    clear_stim();
    rst_n = 1'b0; s_valid = '1; s_last = '1;
    repeat (3) @(posedge clk);
    #2;
    total++; if (s_ready !== '0)  begin bad++; $display("FAIL reset_s_ready got=%b want=0", s_ready); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%b want=0", m_valid); end
    total++; if (m_data !== '0)   begin bad++; $display("FAIL reset_m_data got=%h want=0", m_data); end
    total++; if (m_id !== '0)     begin bad++; $display("FAIL reset_m_id got=%0d want=0", m_id); end
    total++; if (m_qos !== '0)    begin bad++; $display("FAIL reset_m_qos got=%0d want=0", m_qos); end
    total++; if (m_last !== 1'b0) begin bad++; $display("FAIL reset_m_last got=%b want=0", m_last); end
  endtask

  task automatic test_rotation();
    clear_stim();
    for (int i = 0; i < N; i++) begin
      en[i] = 1; rep[i] = 1; plen[i] = 1; base[i] = 8'(16 * (i + 1));
    end
    do_reset();
    repeat (11) cyc();
    total++;
    if (rx_id.size() < 5) begin
      bad++; $display("FAIL rot_count got=%0d want>=5", rx_id.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        total++; if (rx_id[k] != k % N) begin bad++; $display("FAIL rot_id[%0d] got=%0d want=%0d", k, rx_id[k], k % N); end
        total++; if (rx_data[k] !== 8'(16 * (k % N + 1))) begin bad++; $display("FAIL rot_data[%0d] got=%h want=%h", k, rx_data[k], 8'(16 * (k % N + 1))); end
        total++; if (rx_cyc[k] != 2 + 2 * k) begin bad++; $display("FAIL rot_cyc[%0d] got=%0d want=%0d", k, rx_cyc[k], 2 + 2 * k); end
      end
    end
  endtask

  task automatic test_qos();
    int exp_id, exp_q;
    clear_stim();
    for (int i = 1; i < N; i++) begin
      en[i] = 1; rep[i] = 1; plen[i] = 1; base[i] = 8'(8'h40 + i);
    end
    s_qos[1] = 4'd5; s_qos[2] = 4'd9; s_qos[3] = 4'd0;
    do_reset();
    repeat (13) cyc();
    total++;
    if (rx_id.size() < 6) begin
      bad++; $display("FAIL qos_count got=%0d want>=6", rx_id.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        exp_id = (k % 2 == 0) ? 2 : 3;
        exp_q  = (k % 2 == 0) ? 9 : 0;
        total++; if (rx_id[k] != exp_id) begin bad++; $display("FAIL qos_id[%0d] got=%0d want=%0d", k, rx_id[k], exp_id); end
        total++; if (rx_qos[k] != exp_q) begin bad++; $display("FAIL qos_q[%0d] got=%0d want=%0d", k, rx_qos[k], exp_q); end
      end
    end
  endtask

  task automatic test_packet_lock();
    clear_stim();
    en[0] = 1; plen[0] = 4; base[0] = 8'hA0;
    en[1] = 1; rep[1] = 1; plen[1] = 1; base[1] = 8'hB1;
    do_reset();
    repeat (10) cyc();
    for (int c = 1; c <= 4; c++) begin
      total++; if (snap_rdy[c] !== 4'b0001) begin bad++; $display("FAIL lock_ready[c%0d] got=%b want=0001", c, snap_rdy[c]); end
    end
    total++;
    if (rx_id.size() < 5) begin
      bad++; $display("FAIL lock_count got=%0d want>=5", rx_id.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        total++; if (rx_data[k] !== 8'(8'hA0 + k)) begin bad++; $display("FAIL lock_data[%0d] got=%h want=%h", k, rx_data[k], 8'(8'hA0 + k)); end
        total++; if (rx_id[k] != 0) begin bad++; $display("FAIL lock_id[%0d] got=%0d want=0", k, rx_id[k]); end
      end
      total++; if (rx_id[4] != 1 || rx_data[4] !== 8'hB1) begin bad++; $display("FAIL lock_next got=id%0d/%h want=id1/b1", rx_id[4], rx_data[4]); end
      total++; if (rx_cyc[4] != 7) begin bad++; $display("FAIL lock_next_cyc got=%0d want=7", rx_cyc[4]); end
    end
  endtask

  task automatic test_backpressure();
    int exp_cyc [6] = '{2, 3, 7, 8, 9, 10};
    clear_stim();
    en[2] = 1; plen[2] = 6; base[2] = 8'hC0;
    do_reset();
    for (int c = 0; c < 14; c++) begin
      m_ready = !(c >= 4 && c < 7);
      cyc();
    end
    m_ready = 1'b1;
    for (int c = 4; c < 7; c++) begin
      total++; if (snap_rdy[c] !== '0) begin bad++; $display("FAIL bp_ready[c%0d] got=%b want=0000", c, snap_rdy[c]); end
      total++; if (snap_mv[c] !== 1'b1 || snap_md[c] !== 8'hC2) begin bad++; $display("FAIL bp_hold[c%0d] got=%b/%h want=1/c2", c, snap_mv[c], snap_md[c]); end
    end
    total++;
    if (rx_data.size() != 6) begin
      bad++; $display("FAIL bp_count got=%0d want=6", rx_data.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        total++; if (rx_data[k] !== 8'(8'hC0 + k)) begin bad++; $display("FAIL bp_data[%0d] got=%h want=%h", k, rx_data[k], 8'(8'hC0 + k)); end
        total++; if (rx_cyc[k] != exp_cyc[k]) begin bad++; $display("FAIL bp_cyc[%0d] got=%0d want=%0d", k, rx_cyc[k], exp_cyc[k]); end
      end
    end
  endtask

  task automatic test_stall();
    int exp_cyc [5] = '{2, 3, 6, 7, 9};
    clear_stim();
    en[1] = 1; plen[1] = 4; base[1] = 8'hD0; drop_at[1] = 2; drop_left[1] = 2;
    en[3] = 1; rep[3] = 1; plen[3] = 1; base[3] = 8'hE3;
    do_reset();
    repeat (12) cyc();
    total++; if (snap_rdy[3] !== 4'b0010) begin bad++; $display("FAIL stall_ready[c3] got=%b want=0010", snap_rdy[3]); end
    total++; if (snap_rdy[4] !== 4'b0010) begin bad++; $display("FAIL stall_ready[c4] got=%b want=0010", snap_rdy[4]); end
    total++; if (snap_mv[4] !== 1'b0) begin bad++; $display("FAIL stall_valid[c4] got=%b want=0", snap_mv[4]); end
    total++;
    if (rx_id.size() < 5) begin
      bad++; $display("FAIL stall_count got=%0d want>=5", rx_id.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        total++; if (rx_data[k] !== 8'(8'hD0 + k) || rx_id[k] != 1) begin bad++; $display("FAIL stall_beat[%0d] got=id%0d/%h want=id1/%h", k, rx_id[k], rx_data[k], 8'(8'hD0 + k)); end
      end
      for (int k = 0; k < 5; k++) begin
        total++; if (rx_cyc[k] != exp_cyc[k]) begin bad++; $display("FAIL stall_cyc[%0d] got=%0d want=%0d", k, rx_cyc[k], exp_cyc[k]); end
      end
      total++; if (rx_id[4] != 3) begin bad++; $display("FAIL stall_next_id got=%0d want=3", rx_id[4]); end
    end
  endtask

  task automatic test_reset_mid_packet();
    clear_stim();
    en[1] = 1; plen[1] = 1; base[1] = 8'hF1;
    en[3] = 1; plen[3] = 4; base[3] = 8'h30;
    do_reset();
    repeat (5) cyc();
    total++; if (m_valid !== 1'b1 || m_data !== 8'h31) begin bad++; $display("FAIL rmid_pre got=%b/%h want=1/31", m_valid, m_data); end
    #2; rst_n = 1'b0; #1;
    total++; if (m_valid !== 1'b0 || m_data !== '0 || m_id !== '0 || m_qos !== '0 || m_last !== 1'b0)
      begin bad++; $display("FAIL rmid_outputs got=v%b d%h i%0d q%0d l%b want=all 0", m_valid, m_data, m_id, m_qos, m_last); end
    total++; if (s_ready !== '0) begin bad++; $display("FAIL rmid_ready got=%b want=0000", s_ready); end
    clear_stim();
    en[1] = 1; rep[1] = 1; base[1] = 8'h51;
    en[3] = 1; rep[3] = 1; base[3] = 8'h53;
    do_reset();
    repeat (6) cyc();
    total++;
    if (rx_id.size() < 2) begin
      bad++; $display("FAIL rmid_count got=%0d want>=2", rx_id.size());
    end else begin
      total++; if (rx_id[0] != 1) begin bad++; $display("FAIL rmid_first_id got=%0d want=1", rx_id[0]); end
      total++; if (rx_id[1] != 3) begin bad++; $display("FAIL rmid_second_id got=%0d want=3", rx_id[1]); end
    end
  endtask

  // Random traffic against a transaction-level reference model.
  task automatic test_random();
    bit mb, ov, ol, was_idle, acc;
    int mg, mr, oid, best, bestd, d;
    logic [QW-1:0] mql, oq, maxq;
    logic [7:0] od;
    logic [N-1:0] er;
    clear_stim();
    do_reset();
    mb = 0; mg = 0; mr = 0; mql = '0; ov = 0; od = '0; oid = 0; oq = '0; ol = 0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        s_valid[i] = ($urandom_range(0, 99) < 65);
        s_qos[i]   = QW'($urandom_range(0, 2) * 5);
        s_last[i]  = ($urandom_range(0, 2) == 0);
        s_data[i]  = 8'($urandom);
      end
      m_ready = ($urandom_range(0, 3) != 0);
      #1;
      er = '0;
      if (mb && (!ov || m_ready)) er[mg] = 1'b1;
      total++; if (s_ready !== er) begin bad++; $display("FAIL rnd_ready[c%0d] got=%b want=%b", c, s_ready, er); end
      total++; if (m_valid !== ov) begin bad++; $display("FAIL rnd_valid[c%0d] got=%b want=%b", c, m_valid, ov); end
      if (ov) begin
        total++;
        if (m_data !== od || m_id !== IW'(oid) || m_qos !== oq || m_last !== ol) begin
          bad++;
          $display("FAIL rnd_beat[c%0d] got=d%h i%0d q%0d l%b want=d%h i%0d q%0d l%b",
                   c, m_data, m_id, m_qos, m_last, od, oid, oq, ol);
        end
      end
      was_idle = !mb;
      acc = mb && s_valid[mg] && er[mg];
      if (acc) begin
        ov = 1; od = s_data[mg]; oid = mg; oq = mql; ol = s_last[mg];
        if (s_last[mg]) begin mb = 0; mr = (mg + 1) % N; end
      end else if (m_ready) begin
        ov = 0;
      end
      if (was_idle) begin
        maxq = '0;
        for (int i = 0; i < N; i++) if (s_valid[i] && s_qos[i] > maxq) maxq = s_qos[i];
        best = -1; bestd = N;
        for (int i = 0; i < N; i++) begin
          if (s_valid[i] && (s_qos[i] == 0 || s_qos[i] == maxq)) begin
            d = (i - mr + N) % N;
            if (d < bestd) begin bestd = d; best = i; end
          end
        end
        if (best >= 0) begin mb = 1; mg = best; mql = s_qos[best]; end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    m_ready = 1'b1;
    s_valid = '0; s_data = '0; s_qos = '0; s_last = '0;
    test_reset();
    test_rotation();
    test_qos();
    test_packet_lock();
    test_backpressure();
    test_stall();
    test_reset_mid_packet();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_arbiter_qos_pkt.md
Name: stream_arbiter_qos_pkt

Overview:
- Packet-aware N-to-1 stream arbiter with QoS priority and true rotating round-robin among equal-priority streams.
- Grant is held for a whole packet, from grant through the beat carrying s_last_in; there is no mid-packet interleaving.
- Output side is a registered slice with full valid/ready backpressure.
- Sits between multiple producer streams and a single downstream consumer.

Parameters:
- T_DATA_WIDTH, 8: data bus width per stream.
- T_QOS__WIDTH, 4: QoS field width. Larger value means higher priority; 0 is the wildcard priority.
- STREAM_COUNT, 4: number of input streams, at least 2.
- T_ID___WIDTH, $clog2(STREAM_COUNT): width of the stream id output.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- s_data_in  in  [T_DATA_WIDTH-1:0] x STREAM_COUNT  per-stream data.
- s_qos_in  in  [T_QOS__WIDTH-1:0] x STREAM_COUNT  per-stream QoS, sampled at arbitration.
- s_last_in  in  STREAM_COUNT  per-stream end-of-packet flag.
- s_valid_in  in  STREAM_COUNT  per-stream valid.
- s_ready_out  out  STREAM_COUNT  per-stream ready; at most one bit is high.
- m_data_out  out  T_DATA_WIDTH  registered data.
- m_qos_out  out  T_QOS__WIDTH  QoS latched at grant, constant for the packet.
- m_id_out  out  T_ID___WIDTH  index of the granted stream.
- m_last_out  out  1  registered last.
- m_valid_out  out  1  registered valid.
- m_ready_in  in  1  downstream ready.

Behaviour:
- Reset (asynchronous, active-low) sets: state=IDLE, rr_ptr=0, grant=0, and all m_* outputs to 0.
  - s_ready_out is 0 throughout reset.
  - Reset asserted mid-packet drops the packet silently; there is no recovery.
- Candidate set, computed in IDLE:
  - max_q = highest s_qos_in among valid streams with qos != 0.
  - Candidates are valid streams with qos == max_q, or with qos == 0.
  - If no valid stream has nonzero qos, every valid stream is a candidate.
- Winner: the first candidate found scanning indices rr_ptr, rr_ptr+1, ... modulo STREAM_COUNT.
- FSM states:
  - IDLE: s_ready_out = 0. If any candidate exists: grant <= winner, qos_lat <= s_qos_in[winner], go to BUSY. Arbitration costs exactly one cycle, with no data transfer in that cycle.
  - BUSY: s_ready_out[grant] = (!m_valid_out || m_ready_in); all other bits are 0. An input beat is accepted when s_valid_in[grant] && s_ready_out[grant].
- On an accepted beat:
  - Next cycle: m_valid_out=1, m_data_out/m_last_out come from the granted stream, m_id_out=grant, m_qos_out=qos_lat.
  - If the beat had last=1: state <= IDLE and rr_ptr <= (grant+1) mod STREAM_COUNT. The wrap from STREAM_COUNT-1 goes to 0.
- Output register:
  - If m_valid_out && m_ready_in and no new beat is loaded that cycle, then m_valid_out <= 0.
  - Load and drain in the same cycle sustain 1 beat/clk inside a packet.
  - m_* outputs hold stable while m_valid_out && !m_ready_in.
- Latency: 1 clk from input handshake to m_valid_out. Packet-to-packet gap is 1 IDLE cycle.
- Boundary cases:
  - QoS changes on non-granted streams during BUSY are ignored until the next IDLE.
  - A granted stream that drops valid mid-packet keeps the grant; no other stream is served.
  - A single-beat packet (last on first beat) returns to IDLE after that one beat.
  - s_valid_in must not depend on s_ready_out.
  - There is no combinational path from s_*_in to m_*_out.

Test Plan:
- Single beat: streams 0..3 all valid, all qos=0, last=1, m_ready_in=1 → grants in order 0,1,2,3,0 (true rotation), one beat every 2 clks, m_id_out matching.
- QoS priority: stream1 qos=5, stream2 qos=9, stream3 qos=0, stream0 idle, rr_ptr=0 → first grant is 2 (rr_ptr starts at 0, stream 0 not valid). Next grant is 3: rr_ptr=3 and stream3 is qos=0, so it is eligible. Stream1 (qos=5) is never granted while stream2 stays valid at qos 9.
- Packet lock: stream0 sends a 4-beat packet (data 0xA0..0xA3) while stream1 is valid throughout → m_data_out = A0,A1,A2,A3 with m_id_out=0 on every beat. Stream1 is granted only after the last beat.
- Backpressure: m_ready_in low for 3 clks mid-packet → m_* held constant, s_ready_out[grant]=0 while output is full, no beat lost or duplicated. Output resumes at 1 beat/clk.
- Mid-packet stall: granted stream drops valid for 2 clks → m_valid_out goes to 0, grant is retained, other streams' s_ready_out stays 0.
- Reset mid-packet: assert rst_n=0 during beat 2 → all outputs 0 immediately. After release, arbitration restarts from rr_ptr=0.
